gpio_bus_responder: RTL

// - Memory-mapped GPIO responder on the peripheral side of the data-bus address decoder.
// - Decoder routes GPIO_1 (offset 0x0024) and GPIO_2 (offset 0x0028) accesses here with selector[1] set.
// - This block executes the access, returns read data on Data_out (fed to the decoder's GPIO data input),

---
 rtl/gpio_bus_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/gpio_bus_responder.sv
// gpio_bus_responder: memory-mapped GPIO register pair with edge-latching interrupt
module gpio_bus_responder #(
    parameter int              WIDTH       = 8,
    parameter int              WAIT_STATES = 1,
    parameter logic [WIDTH-1:0] RESET_OUT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       selector_in,
    input  logic [31:0]      Adr_in,
    input  logic             MemWrite_in,
    input  logic             MemRead_in,
    input  logic [31:0]      WriteData_in,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [31:0]      Data_out,
    output logic             ready_out,
    output logic [WIDTH-1:0] gpio_out,
    output logic             irq_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;
    state_t           state;
    logic [3:0]       count;
    logic [15:0]      addr;
    logic             wr, rd;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] s1, sync, prev, edges;
    logic             req, fire, clr;
    logic             unused_ok;
    assign req       = selector_in[1] & (MemWrite_in | MemRead_in);
    assign fire      = state == BUSY && count == WAIT_STATES[3:0];
    assign clr       = fire && rd && !wr && addr == 16'h0028;
    assign unused_ok = ^{selector_in[2], selector_in[0], Adr_in[31:16], WriteData_in[31:WIDTH]};
    // synchronize pins, latch both-polarity edges, clear only the flags a GPIO_2 read returned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= '0;
            sync    <= '0;
            prev    <= '0;
            edges   <= '0;
            irq_out <= 1'b0;
        end else begin
            s1      <= gpio_in;
            sync    <= s1;
            prev    <= sync;
            edges   <= (sync ^ prev) | (clr ? '0 : edges);
            irq_out <= |edges;
        end
    end
    // access sequencer: the access executes on the edge that raises ready_out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            addr      <= '0;
            wr        <= 1'b0;
            rd        <= 1'b0;
            wdata     <= '0;
            ready_out <= 1'b0;
            gpio_out  <= RESET_OUT;
            Data_out  <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state <= BUSY;
                    addr  <= Adr_in[15:0];
                    wr    <= MemWrite_in;
                    rd    <= MemRead_in;
                    wdata <= WriteData_in[WIDTH-1:0];
                    count <= '0;
                end
                BUSY: begin
                    count <= count + 4'd1;
                    if (fire) begin
                        state     <= DONE;
                        ready_out <= 1'b1;
                        if (addr == 16'h0024) begin
                            if (wr)
                                gpio_out <= wdata;
                            else
                                Data_out <= 32'(gpio_out);
                        end else if (addr == 16'h0028) begin
                            if (!wr)
                                Data_out <= {16'(edges), 16'(sync)};
                        end else begin
                            Data_out <= '0;
                        end
                    end
                end
                DONE: begin
                    ready_out <= 1'b0;
                    state     <= HOLD;
                end
                default: if (!req) state <= IDLE;
            endcase
        end
    end
endmodule
